// File: rtl/pio_key_pkg.sv
// Shared definitions for the push-button PIO controller: register addresses,
// default key polarity and a counter-width helper.
package pio_key_pkg;

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_RAW   = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  // Board keys pull the pin low when pressed.
  localparam bit KEY_ACTIVE_LOW = 1'b1;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pio_key_event_ctrl_if.sv
// Avalon-MM slave bus of the key controller (word-addressed, 4 registers).
interface pio_key_event_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_key_event_ctrl_key_debounce.sv
// One key: 2-flop synchroniser, polarity correction, debounce counter, stable
// state and a one-cycle press pulse. Define KEY_AUTOREPEAT_EN to add the
// hold-to-repeat counter that emits extra press pulses while the key is held.
module key_debounce
  import pio_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = KEY_ACTIVE_LOW,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic synced,
  output logic stable,
  output logic press
);

  localparam int unsigned   CW           = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          RELEASED_PIN = ACTIVE_LOW;

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          press_q;
  logic          rise;
  logic          rep_fire;

  assign synced = sync2_q ^ ACTIVE_LOW;
  assign stable = stable_q;
  assign press  = press_q;

  // Debounced 0->1 transition happens on this edge.
  assign rise = synced && !stable_q && (cnt_q == CNT_LAST);

  // Synchronise the pin and debounce it; any disagreement resets the window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= RELEASED_PIN;
      sync2_q  <= RELEASED_PIN;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      press_q <= rise | rep_fire;
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = cnt_width(RMAX);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_q;
  logic          rep_phase_q;  // 0: waiting for first repeat, 1: periodic

  assign rep_fire = stable_q && (rep_phase_q ? (rep_cnt_q == REP_NEXT)
                                             : (rep_cnt_q == REP_FIRST));

  // Repeat counter runs only while the debounced key is held.
  always_ff @(posedge clk) begin
    if (!reset_n || !stable_q) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b1;
    end else begin
      rep_cnt_q <= rep_cnt_q + RW'(1);
    end
  end
`else
  // Repeat timing has no effect without the repeat logic.
  assign rep_fire = (REPEAT_DELAY == 0) & (REPEAT_PERIOD == 0) & 1'b0;
`endif

endmodule

// File: rtl/pio_key_event_ctrl.sv
// Push-button PIO controller: per-key debounce, press-event edge capture,
// maskable level interrupt and an Avalon-MM register slave.
// Optional feature macro: KEY_AUTOREPEAT_EN (hold-to-repeat press events).
module pio_key_event_ctrl
  import pio_key_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = KEY_ACTIVE_LOW,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_key_event_ctrl_if.slave  avs,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .synced  (synced[i]),
      .stable  (stable[i]),
      .press   (press[i])
    );
  end

  assign wr_en = avs.chipselect && !avs.write_n;

  // Edge capture next state: write-1-to-clear, a press in the same cycle wins.
  always_comb begin
    edge_clr = '0;
    if (wr_en && (avs.address == ADDR_EDGE)) begin
      edge_clr = avs.writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~edge_clr) | press;
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    unique case (avs.address)
      ADDR_STATE: rd_mux[WIDTH-1:0] = stable;
      ADDR_RAW:   rd_mux[WIDTH-1:0] = synced;
      ADDR_MASK:  rd_mux[WIDTH-1:0] = irqmask_q;
      ADDR_EDGE:  rd_mux[WIDTH-1:0] = edge_q;
      default:    rd_mux = '0;
    endcase
  end

  // Register file, interrupt and registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask_q    <= '0;
      edge_q       <= '0;
      irq          <= 1'b0;
      avs.readdata <= '0;
    end else begin
      if (wr_en && (avs.address == ADDR_MASK)) begin
        irqmask_q <= avs.writedata[WIDTH-1:0];
      end
      edge_q       <= edge_d;
      irq          <= |(edge_q & irqmask_q);
      avs.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_key_event_ctrl.sv
// Self-checking bench for pio_key_event_ctrl (DEBOUNCE_CYCLES=4, active-low
// keys, repeat delay/period 10/5 when KEY_AUTOREPEAT_EN is defined).
`timescale 1ns/1ps
module tb_pio_key_event_ctrl;
  import pio_key_pkg::*;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEB   = 4;
  localparam int unsigned RDLY  = 10;
  localparam int unsigned RPER  = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_port;
  logic             irq;
  int               total = 0;
  int               bad = 0;
  int unsigned      cyc = 0;

  pio_key_event_ctrl_if bus();

  pio_key_event_ctrl #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (1'b1),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  typedef struct {
    string       name;
    bit          wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a read; the expectation is queued now and compared when readdata lands.
  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] e,
                          input logic ei);
    exp_t x;
    bus.address = a;
    x.name = name;
    x.rd   = e;
    x.irq  = ei;
    sb.push_back(x);
    @(negedge clk);
    x = sb.pop_front();
    check({x.name, ".rd"}, bus.readdata, x.rd);
    check({x.name, ".irq"}, {31'b0, irq}, {31'b0, x.irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  function automatic vec_t mk(input string n, input bit w, input logic [1:0] wa,
                              input logic [31:0] wd, input logic [1:0] ra,
                              input logic [31:0] e);
    vec_t v;
    v.name = n; v.wr = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = e;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t[4];
    int n;
    int unsigned lim;

    vecs.push_back(mk("rst_state",    0, 0, 0,            ADDR_STATE, 0));
    vecs.push_back(mk("rst_raw",      0, 0, 0,            ADDR_RAW,   0));
    vecs.push_back(mk("rst_mask",     0, 0, 0,            ADDR_MASK,  0));
    vecs.push_back(mk("rst_edge",     0, 0, 0,            ADDR_EDGE,  0));
    vecs.push_back(mk("wr_state_ign", 1, 0, 32'hFFFFFFFF, ADDR_STATE, 0));
    vecs.push_back(mk("wr_raw_ign",   1, 1, 32'hFFFFFFFF, ADDR_RAW,   0));
    vecs.push_back(mk("mask_all",     1, 2, 32'hFFFFFFFF, ADDR_MASK,  32'h3));
    vecs.push_back(mk("mask_one",     1, 2, 32'h00000001, ADDR_MASK,  32'h1));
    vecs.push_back(mk("edge_w1c_idl", 1, 3, 32'hFFFFFFFF, ADDR_EDGE,  0));
    vecs.push_back(mk("mask_zero",    1, 2, 32'h0,        ADDR_MASK,  0));

    in_port        = 2'b11;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset_n        = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_readdata", bus.readdata, 0);
    check("rst_irq", {31'b0, irq}, 0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata);
      read_chk(vecs[i].name, vecs[i].raddr, vecs[i].exp, 1'b0);
    end

    // Clean press of key 0: stable after DEB+2 edges, visible one edge later.
    bus.address = ADDR_STATE;
    in_port[0]  = 1'b0;
    cycles(6);
    check("press_state_early", bus.readdata, 0);
    @(negedge clk);
    check("press_state", bus.readdata, 32'h1);
    read_chk("press_raw", ADDR_RAW, 32'h1, 1'b0);
    read_chk("press_edge", ADDR_EDGE, 32'h1, 1'b0);

    // Clear while held, then release: a release must not capture an event.
    wr(ADDR_EDGE, 32'h1);
    in_port[0] = 1'b1;
    cycles(10);
    read_chk("release_state", ADDR_STATE, 0, 1'b0);
    read_chk("release_no_evt", ADDR_EDGE, 0, 1'b0);

    // 3-cycle glitch on key 1 is one short of the debounce window.
    in_port[1] = 1'b0;
    cycles(3);
    in_port[1] = 1'b1;
    cycles(10);
    read_chk("glitch_state", ADDR_STATE, 0, 1'b0);
    read_chk("glitch_edge", ADDR_EDGE, 0, 1'b0);

    // Interrupt path: mask both, press key 1.
    wr(ADDR_MASK, 32'h3);
    bus.address = ADDR_EDGE;
    in_port[1]  = 1'b0;
    cycles(7);
    check("irq_not_yet", {31'b0, irq}, 0);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 1);
    check("irq_edge", bus.readdata, 32'h2);
    wr(ADDR_EDGE, 32'h2);
    check("w1c_irq_hold", {31'b0, irq}, 1);
    @(negedge clk);
    check("w1c_irq_clr", {31'b0, irq}, 0);
    check("w1c_edge_clr", bus.readdata, 0);

    // Release key 1, then set and clear of key 0 on the same edge.
    in_port[1] = 1'b1;
    cycles(10);
    read_chk("pre_sim_edge", ADDR_EDGE, 0, 1'b0);
    in_port[0] = 1'b0;
    cycles(6);
    wr(ADDR_EDGE, 32'h1);
    read_chk("set_wins", ADDR_EDGE, 32'h1, 1'b1);

`ifdef KEY_AUTOREPEAT_EN
    in_port[0] = 1'b1;
    cycles(15);
    wr(ADDR_EDGE, 32'h3);
    wr(ADDR_MASK, 32'h0);
    bus.address = ADDR_EDGE;
    in_port[0]  = 1'b0;
    n   = 0;
    lim = cyc + 200;
    while (n < 4 && cyc < lim) begin
      @(negedge clk);
      if (bus.readdata[0]) begin
        t[n] = int'(cyc);
        n++;
        wr(ADDR_EDGE, 32'h1);
      end
    end
    check("rep_count", 32'(n), 32'd4);
    if (n == 4) begin
      check("rep_first", 32'(t[1] - t[0]), 32'(RDLY));
      check("rep_second", 32'(t[2] - t[1]), 32'(RPER));
      check("rep_third", 32'(t[3] - t[2]), 32'(RPER));
    end
    in_port[0] = 1'b1;
    cycles(12);
    wr(ADDR_EDGE, 32'h1);
    cycles(30);
    read_chk("rep_stop", ADDR_EDGE, 0, 1'b0);
`else
    // Holding a key yields exactly one event.
    cycles(40);
    wr(ADDR_EDGE, 32'h1);
    cycles(40);
    read_chk("no_repeat", ADDR_EDGE, 0, 1'b0);
    in_port[0] = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
